// File: rtl/multicycle_control.sv
// Multicycle datapath controller: Moore state outputs plus the Mealy fetch
// strobes, with a sticky HALT on unsupported opcodes.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] instruction,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        Reg2Loc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        IorD,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCSource,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        illegal,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    LDWB   = 4'd4,
    MEMWR  = 4'd5,
    REXEC  = 4'd6,
    RWB    = 4'd7,
    CBZ    = 4'd8,
    BR     = 4'd9,
    HALT   = 4'd15
  } state_t;

  state_t state_q, state_d, cur_s;
  logic   is_ldur, is_stur, is_cbz;

  // The branch is taken by the datapath gating PCWriteCond with zero.
  logic unused_zero;
  assign unused_zero = zero;

  assign is_ldur = (instruction == 11'b11111000010);
  assign is_stur = (instruction == 11'b11111000000);
  assign is_cbz  = (instruction[10:3] == 8'b10110100);

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // While reset is held the outputs already show FETCH, so nothing
  // half-finished (e.g. a pending store) reaches the datapath.
  assign cur_s   = reset ? FETCH : state_q;
  assign state   = cur_s;
  assign illegal = (cur_s == HALT);

  always_comb begin
    state_d     = FETCH;
    Reg2Loc     = is_stur | is_cbz;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    IorD        = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    case (cur_s)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_ready && !reset) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = DECODE;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        casez (instruction)
          11'b1??0101?000: state_d = REXEC;
          11'b11111000010: state_d = MEMADR;
          11'b11111000000: state_d = MEMADR;
          11'b10110100???: state_d = CBZ;
          11'b000101?????: state_d = BR;
          default:         state_d = HALT;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = is_ldur ? MEMRD : MEMWR;
      end
      MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        state_d = mem_ready ? LDWB : MEMRD;
      end
      LDWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        state_d  = mem_ready ? FETCH : MEMWR;
      end
      REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = RWB;
      end
      RWB: RegWrite = 1'b1;
      CBZ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
      end
      BR: begin
        PCWrite  = 1'b1;
        PCSource = 1'b1;
      end
      HALT: begin
        Reg2Loc = 1'b0;
        state_d = HALT;
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control words are
// queued by the stimulus and checked by an independent monitor on the falling edge.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] instruction = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite, IRWrite, IorD;
  logic        PCWrite, PCWriteCond, PCSource, ALUSrcA, illegal;
  logic [1:0]  ALUSrcB, ALUOp;
  logic [3:0]  state;

  multicycle_control dut (
    .clk(clk), .reset(reset), .instruction(instruction), .zero(zero),
    .mem_ready(mem_ready), .Reg2Loc(Reg2Loc), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .IorD(IorD), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .PCSource(PCSource), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       r2l, m2r, rw, mr, mw, irw, iord, pcw, pcwc, pcs, asa;
    logic [1:0] asb, aop;
    logic       ill;
  } exp_t;

  typedef struct {
    exp_t  e;
    string tag;
  } item_t;

  item_t exp_q[$];
  int    n_vec  = 0;
  int    n_fail = 0;

  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_B = 4, K_ILL = 5;

  function automatic int classify(input logic [10:0] ins);
    if ((ins & 11'b10011110111) == 11'b10001010000) return K_R;
    if (ins == LDUR) return K_LD;
    if (ins == STUR) return K_ST;
    if ((ins & 11'b11111111000) == 11'b10110100000) return K_CBZ;
    if ((ins & 11'b11111100000) == 11'b00010100000) return K_B;
    return K_ILL;
  endfunction

  // Control word required in a given state, straight from the state/output table.
  function automatic exp_t model(input logic [3:0] st, input logic rst,
                                 input logic mr, input logic [10:0] ins);
    exp_t e;
    e     = '0;
    e.st  = st;
    e.r2l = (classify(ins) == K_ST) || (classify(ins) == K_CBZ);
    case (st)
      4'd0: begin
        e.mr = 1'b1; e.asb = 2'b01;
        if (mr && !rst) begin e.irw = 1'b1; e.pcw = 1'b1; end
      end
      4'd1: e.asb = 2'b11;
      4'd2: begin e.asa = 1'b1; e.asb = 2'b10; end
      4'd3: begin e.iord = 1'b1; e.mr = 1'b1; end
      4'd4: begin e.m2r = 1'b1; e.rw = 1'b1; end
      4'd5: begin e.iord = 1'b1; e.mw = 1'b1; end
      4'd6: begin e.asa = 1'b1; e.aop = 2'b10; end
      4'd7: e.rw = 1'b1;
      4'd8: begin e.asa = 1'b1; e.aop = 2'b01; e.pcwc = 1'b1; e.pcs = 1'b1; end
      4'd9: begin e.pcw = 1'b1; e.pcs = 1'b1; end
      4'd15: begin e = '0; e.st = st; e.ill = 1'b1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic step(input logic rst, input logic mr, input logic z,
                      input logic [10:0] ins, input logic [3:0] st, input string tag);
    item_t it;
    reset       = rst;
    mem_ready   = mr;
    zero        = z;
    instruction = ins;
    it.e   = model(st, rst, mr, ins);
    it.tag = tag;
    exp_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  // One complete instruction: fw fetch waits, mw memory waits.
  task automatic run_instr(input logic [10:0] ins, input int fw, input int mw,
                           input logic z, input string tag);
    int k;
    k = classify(ins);
    for (int i = 0; i < fw; i++) step(1'b0, 1'b0, z, ins, 4'd0, tag);
    step(1'b0, 1'b1, z, ins, 4'd0, tag);
    step(1'b0, 1'($urandom), z, ins, 4'd1, tag);
    case (k)
      K_R: begin
        step(1'b0, 1'($urandom), z, ins, 4'd6, tag);
        step(1'b0, 1'($urandom), z, ins, 4'd7, tag);
      end
      K_LD: begin
        step(1'b0, 1'($urandom), z, ins, 4'd2, tag);
        for (int i = 0; i < mw; i++) step(1'b0, 1'b0, z, ins, 4'd3, tag);
        step(1'b0, 1'b1, z, ins, 4'd3, tag);
        step(1'b0, 1'($urandom), z, ins, 4'd4, tag);
      end
      K_ST: begin
        step(1'b0, 1'($urandom), z, ins, 4'd2, tag);
        for (int i = 0; i < mw; i++) step(1'b0, 1'b0, z, ins, 4'd5, tag);
        step(1'b0, 1'b1, z, ins, 4'd5, tag);
      end
      K_CBZ: step(1'b0, 1'($urandom), z, ins, 4'd8, tag);
      K_B:   step(1'b0, 1'($urandom), z, ins, 4'd9, tag);
      default: begin
        for (int i = 0; i < 10; i++) step(1'b0, 1'($urandom), z, ins, 4'd15, tag);
        step(1'b1, 1'($urandom), z, ins, 4'd0, {tag, "_rst"});
      end
    endcase
  endtask

  function automatic logic [10:0] gen_instr(input int k);
    logic [31:0] r;
    logic [10:0] ins;
    r = $urandom;
    case (k)
      K_R:   ins = {1'b1, r[1:0], 4'b0101, r[2], 3'b000};
      K_LD:  ins = LDUR;
      K_ST:  ins = STUR;
      K_CBZ: ins = {8'b10110100, r[2:0]};
      K_B:   ins = {6'b000101, r[4:0]};
      default: begin
        ins = r[10:0];
        for (int i = 0; i < 64 && classify(ins) != K_ILL; i++) begin
          r   = $urandom;
          ins = r[10:0];
        end
        if (classify(ins) != K_ILL) ins = 11'b11111111111;
      end
    endcase
    return ins;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      item_t it;
      exp_t  act;
      it  = exp_q.pop_front();
      act = {state, Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite, IRWrite, IorD,
             PCWrite, PCWriteCond, PCSource, ALUSrcA, ALUSrcB, ALUOp, illegal};
      n_vec++;
      if (act !== it.e) begin
        n_fail++;
        $display("FAIL %s state=%0d: got %h required %h", it.tag, it.e.st, act, it.e);
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 1'b0, 11'b10001011000, 4'd0, "reset_hold");
    step(1'b1, 1'b0, 1'b0, 11'b10001011000, 4'd0, "reset_hold");

    run_instr(11'b10001011000, 0, 0, 1'b0, "add");
    run_instr(LDUR, 0, 3, 1'b0, "ldur_wait3");
    run_instr(STUR, 0, 0, 1'b0, "stur");
    run_instr(11'b10110100101, 0, 0, 1'b1, "cbz_z1");
    run_instr(11'b10110100101, 0, 0, 1'b0, "cbz_z0");
    run_instr(11'b00010100011, 1, 0, 1'b0, "b");
    run_instr(11'b11111111111, 0, 0, 1'b0, "halt");
    step(1'b0, 1'b0, 1'b0, 11'b11111111111, 4'd0, "post_halt");

    // Reset lands while a store is still waiting on memory.
    step(1'b0, 1'b1, 1'b0, STUR, 4'd0, "rst_memwr");
    step(1'b0, 1'b1, 1'b0, STUR, 4'd1, "rst_memwr");
    step(1'b0, 1'b1, 1'b0, STUR, 4'd2, "rst_memwr");
    step(1'b0, 1'b0, 1'b0, STUR, 4'd5, "rst_memwr");
    step(1'b0, 1'b0, 1'b0, STUR, 4'd5, "rst_memwr");
    step(1'b1, 1'b0, 1'b0, STUR, 4'd0, "rst_memwr_hold");
    step(1'b0, 1'b0, 1'b0, STUR, 4'd0, "rst_memwr_after");

    for (int n = 0; n < 80; n++) begin
      int k;
      k = int'($urandom_range(0, 5));
      run_instr(gen_instr(k), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                1'($urandom), "random");
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit, synchronous and active-high.
REQ-003 The block SHALL have the port instruction, input, 11 bits, opcode field IR[31:21] from the instruction register.
REQ-004 The block SHALL have the port zero, input, 1 bit, ALU zero flag.
REQ-005 The block SHALL have the port mem_ready, input, 1 bit, memory access complete this cycle.
REQ-006 The block SHALL have the ports Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite, IRWrite, IorD, PCWrite, PCWriteCond, PCSource and ALUSrcA, each an output of 1 bit, carrying the datapath controls of the same names.
REQ-007 The block SHALL have the port ALUSrcB, output, 2 bits: 00=reg B, 01=constant 4, 10=sign-extended offset, 11=offset<<2.
REQ-008 The block SHALL have the port ALUOp, output, 2 bits: 00=add, 01=pass-B/zero test, 10=funct decode.
REQ-009 The block SHALL have the port illegal, output, 1 bit, sticky unsupported-opcode flag.
REQ-010 The block SHALL have the port state, output, 4 bits, current FSM state for debug.

Function
REQ-011 The block SHALL implement the state encodings FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, LDWB=4, MEMWR=5, REXEC=6, RWB=7, CBZ=8, BR=9 and HALT=15; any other value SHALL transition to FETCH.
REQ-012 The block SHALL drive every output not explicitly listed for a state to 0.
REQ-013 In FETCH the block SHALL drive IorD=0, MemRead=1, ALUSrcA=0 and ALUSrcB=01, and hold FETCH while mem_ready=0.
REQ-014 In FETCH with mem_ready=1 the block SHALL assert IRWrite=1 and PCWrite=1 (PCSource=0) for that one cycle only (Mealy) and go to DECODE.
REQ-015 In DECODE the block SHALL drive ALUSrcA=0 and ALUSrcB=11 (branch target precomputed) and branch on instruction.
REQ-016 The DECODE transitions SHALL be: 1xx0101x000 -> REXEC; 11111000010 (LDUR) -> MEMADR; 11111000000 (STUR) -> MEMADR; 10110100xxx (CBZ) -> CBZ; 000101xxxxx (B) -> BR; anything else -> HALT.
REQ-017 The block SHALL drive Reg2Loc=1 in every state when instruction matches STUR or CBZ, and 0 otherwise.
REQ-018 In MEMADR the block SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=00, then go to MEMRD for LDUR or MEMWR for STUR.
REQ-019 In MEMRD the block SHALL drive IorD=1 and MemRead=1, hold while mem_ready=0, and go to LDWB on mem_ready=1.
REQ-020 In LDWB the block SHALL drive MemtoReg=1 and RegWrite=1, then go to FETCH.
REQ-021 In MEMWR the block SHALL drive IorD=1 and MemWrite=1, hold while mem_ready=0, and go to FETCH on mem_ready=1.
REQ-022 In REXEC the block SHALL drive ALUSrcA=1, ALUSrcB=00 and ALUOp=10, then go to RWB.
REQ-023 In RWB the block SHALL drive RegWrite=1 and MemtoReg=0, then go to FETCH.
REQ-024 In CBZ the block SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1 and PCSource=1, then go to FETCH; the PC is updated only if zero=1, which the datapath gates.
REQ-025 In BR the block SHALL drive PCWrite=1 and PCSource=1, then go to FETCH.
REQ-026 In HALT the block SHALL drive illegal=1 with all other outputs 0, and remain in HALT until reset.
REQ-027 The block SHALL never assert MemRead and MemWrite in the same cycle, and SHALL never assert RegWrite in a memory-wait cycle.
REQ-028 Instruction latency SHALL be as follows, each counted with zero wait states and including FETCH: R-type 4, LDUR 5, STUR 4, CBZ 3, B 3 cycles; every mem_ready=0 cycle adds exactly one cycle.

Reset
REQ-029 With reset=1 at a rising edge the block SHALL enter FETCH, clear illegal, and take priority over every transition, including mid-access (MEMRD or MEMWR waits).
REQ-030 During reset the outputs SHALL reflect FETCH with IRWrite=0 and PCWrite=0 regardless of mem_ready.
REQ-031 The first fetch SHALL begin in the cycle after reset deasserts.

Verification
REQ-032 The bench SHALL apply reset, then instruction=10001011000 (ADD) with mem_ready=1, and check the states 0,1,6,7,0, with RegWrite=1 only in state 7 and ALUOp=10 in state 6.
REQ-033 The bench SHALL apply LDUR 11111000010 with mem_ready low for 3 cycles in MEMRD, and check MemRead=1 and IorD=1 held for 4 cycles, then LDWB with MemtoReg=1 and RegWrite=1, for 8 cycles total.
REQ-034 The bench SHALL apply STUR 11111000000, and check Reg2Loc=1 throughout, MemWrite=1 in state 5 only, and no RegWrite in any cycle.
REQ-035 The bench SHALL apply CBZ 10110100101 with zero=1 and then zero=0, and check that both show PCWriteCond=1, PCSource=1 and ALUOp=01 in state 8, and return to FETCH after 3 cycles.
REQ-036 The bench SHALL apply opcode 11111111111, and check HALT (state=15) with illegal=1 held for 10 cycles, then reset=1, and check state=0 and illegal=0 after the next edge.
REQ-037 The bench SHALL assert reset during a MEMWR wait, and check MemWrite=0 and state=0 on the following cycle.
